// File: rtl/card_dealer.sv
// Card dealer: captures a 52-card shuffled stream into a deck memory, then deals
// cards in capture order with rank and blackjack-value decode.
module card_dealer #(
  parameter int unsigned LOW_THRESH = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       loadFlag,
  input  logic [5:0] card,
  input  logic       deal_req,
  output logic       ready,
  output logic       deal_valid,
  output logic [5:0] card_out,
  output logic [3:0] rank,
  output logic [3:0] value,
  output logic [5:0] remaining,
  output logic       deck_low,
  output logic       deck_empty,
  output logic       deal_err
);

  localparam logic [5:0] LowThresh = 6'(LOW_THRESH);

  typedef enum logic [1:0] {StLoad, StReady, StEmpty} state_e;

  state_e     state_q, state_d;
  logic [5:0] wr_ptr_q, wr_ptr_d;
  logic [5:0] rd_ptr_q, rd_ptr_d;
  logic [5:0] last_q, last_d;
  logic [5:0] remaining_q, remaining_d;
  logic [5:0] card_out_q, card_out_d;
  logic [3:0] rank_q, rank_d;
  logic [3:0] value_q, value_d;
  logic       deal_valid_q, deal_valid_d;
  logic       deal_err_q, deal_err_d;

  logic [5:0] deck_q [52];

  logic       capture;
  logic [5:0] rd_card;
  logic [3:0] rd_rank;
  logic [3:0] rd_value;

  // A held card is captured once; out-of-range codes never touch last_q.
  assign capture  = (state_q == StLoad) && loadFlag && (card != last_q) && (card <= 6'd51);
  assign rd_card  = deck_q[rd_ptr_q];
  assign rd_rank  = 4'(rd_card % 6'd13) + 4'd1;
  assign rd_value = (rd_rank == 4'd1) ? 4'd11 : (rd_rank >= 4'd11) ? 4'd10 : rd_rank;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    last_d       = last_q;
    remaining_d  = remaining_q;
    card_out_d   = card_out_q;
    rank_d       = rank_q;
    value_d      = value_q;
    deal_valid_d = 1'b0;
    deal_err_d   = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (capture) begin
          wr_ptr_d = wr_ptr_q + 6'd1;
          last_d   = card;
          if (wr_ptr_q == 6'd51) begin
            state_d     = StReady;
            remaining_d = 6'd52;
            rd_ptr_d    = 6'd0;
          end
        end
        deal_err_d = deal_req;
      end
      StReady: begin
        if (deal_req) begin
          deal_valid_d = 1'b1;
          card_out_d   = rd_card;
          rank_d       = rd_rank;
          value_d      = rd_value;
          rd_ptr_d     = rd_ptr_q + 6'd1;
          remaining_d  = remaining_q - 6'd1;
          if (remaining_q == 6'd1) state_d = StEmpty;
        end
      end
      StEmpty: deal_err_d = deal_req;
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StLoad;
      wr_ptr_q     <= 6'd0;
      rd_ptr_q     <= 6'd0;
      last_q       <= 6'h3F;
      remaining_q  <= 6'd0;
      card_out_q   <= 6'd0;
      rank_q       <= 4'd0;
      value_q      <= 4'd0;
      deal_valid_q <= 1'b0;
      deal_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      last_q       <= last_d;
      remaining_q  <= remaining_d;
      card_out_q   <= card_out_d;
      rank_q       <= rank_d;
      value_q      <= value_d;
      deal_valid_q <= deal_valid_d;
      deal_err_q   <= deal_err_d;
    end
  end

  // Deck storage is not reset; wr_ptr_q only reaches 51 while capturing.
  always_ff @(posedge clk) begin
    if (!rst && capture) deck_q[wr_ptr_q] <= card;
  end

  assign ready      = (state_q == StReady);
  assign deck_empty = (state_q == StEmpty);
  assign deck_low   = ready && (remaining_q <= LowThresh);
  assign remaining  = remaining_q;
  assign card_out   = card_out_q;
  assign rank       = rank_q;
  assign value      = value_q;
  assign deal_valid = deal_valid_q;
  assign deal_err   = deal_err_q;

endmodule

// File: tb/tb_card_dealer.sv
// Randomized bench for card_dealer against a queue-based model of the deck.
module tb_card_dealer;

  localparam int unsigned LowThresh = 15;

  logic       clk = 1'b0;
  logic       rst, loadFlag, deal_req;
  logic [5:0] card;
  logic       ready, deal_valid, deck_low, deck_empty, deal_err;
  logic [5:0] card_out, remaining;
  logic [3:0] rank, value;

  always #5 clk = ~clk;

  card_dealer #(.LOW_THRESH(LowThresh)) dut (
    .clk       (clk),
    .rst       (rst),
    .loadFlag  (loadFlag),
    .card      (card),
    .deal_req  (deal_req),
    .ready     (ready),
    .deal_valid(deal_valid),
    .card_out  (card_out),
    .rank      (rank),
    .value     (value),
    .remaining (remaining),
    .deck_low  (deck_low),
    .deck_empty(deck_empty),
    .deal_err  (deal_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: captured cards in order, count dealt, last outputs.
  int m_q[$];
  int m_last;
  int m_dealt;
  bit m_loaded;
  bit m_dv, m_err;
  int m_card, m_rank, m_value;

  int perm[52];

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_rem();
    return m_loaded ? 52 - m_dealt : 0;
  endfunction

  function automatic int value_of(input int r);
    if (r == 1) return 11;
    if (r >= 11) return 10;
    return r;
  endfunction

  task automatic model_edge();
    m_dv  = 0;
    m_err = 0;
    if (rst) begin
      m_q.delete();
      m_last   = 63;
      m_dealt  = 0;
      m_loaded = 0;
      m_card   = 0;
      m_rank   = 0;
      m_value  = 0;
    end else if (!m_loaded) begin
      if (loadFlag && int'(card) != m_last && card <= 51) begin
        m_q.push_back(int'(card));
        m_last = int'(card);
        if (m_q.size() == 52) m_loaded = 1;
      end
      m_err = deal_req;
    end else if (m_dealt < 52) begin
      if (deal_req) begin
        m_card  = m_q[m_dealt];
        m_rank  = m_card % 13 + 1;
        m_value = value_of(m_rank);
        m_dv    = 1;
        m_dealt++;
      end
    end else begin
      m_err = deal_req;
    end
  endtask

  task automatic compare_all();
    bit exp_ready;
    exp_ready = m_loaded && m_dealt < 52;
    check_eq("ready", ready, exp_ready);
    check_eq("deal_valid", deal_valid, m_dv);
    check_eq("deal_err", deal_err, m_err);
    check_eq("deck_empty", deck_empty, m_loaded && m_dealt == 52);
    check_eq("deck_low", deck_low, exp_ready && m_rem() <= LowThresh);
    check_eq("remaining", remaining, m_rem());
    check_eq("card_out", card_out, m_card);
    check_eq("rank", rank, m_rank);
    check_eq("value", value, m_value);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic shuffle_from(input int start);
    for (int i = 51; i > start; i--) begin
      int j, t;
      j = $urandom_range(start, i);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
  endtask

  task automatic stream(input bit rnd, input int hold, input int start);
    loadFlag = 1;
    for (int i = start; i < 52; i++) begin
      int h;
      if (rnd && $urandom_range(0, 4) == 0) begin
        card     = 6'($urandom_range(52, 63));
        deal_req = (i < 51) && ($urandom_range(0, 1) == 1);
        tick();
      end
      card = 6'(perm[i]);
      h = rnd ? $urandom_range(1, 3) : hold;
      repeat (h) begin
        deal_req = rnd && (i < 51) && ($urandom_range(0, 7) == 0);
        tick();
      end
    end
    deal_req = 0;
  endtask

  task automatic deal_until(input int target);
    int cyc = 0;
    while (m_rem() > target && cyc < 2000) begin
      deal_req = $urandom_range(0, 1);
      tick();
      cyc++;
    end
    deal_req = 0;
    tick();
    check_eq("deal_until_remaining", remaining, target);
  endtask

  task automatic do_reset();
    rst      = 1;
    loadFlag = 0;
    tick();
    rst      = 0;
  endtask

  initial begin
    int exp_r[5];
    int exp_v[5];
    int idx;
    exp_r = '{1, 11, 12, 13, 1};
    exp_v = '{11, 10, 10, 10, 11};

    rst = 1; loadFlag = 0; card = 6'd0; deal_req = 0;
    repeat (2) tick();
    check_eq("rst_remaining", remaining, 0);
    check_eq("rst_ready", ready, 0);
    rst = 0;

    // loadFlag low: nothing captured, deal requests rejected.
    repeat (4) begin
      card     = 6'($urandom_range(0, 63));
      deal_req = $urandom_range(0, 1);
      tick();
    end
    deal_req = 0;

    // In-order load, each card held two cycles.
    for (int i = 0; i < 52; i++) perm[i] = i;
    stream(0, 2, 0);
    check_eq("load_ready", ready, 1);
    check_eq("load_remaining", remaining, 52);
    check_eq("load_low", deck_low, 0);
    deal_until(0);
    check_eq("empty_flag", deck_empty, 1);
    check_eq("empty_ready", ready, 0);
    deal_req = 1;
    tick();
    check_eq("empty_err", deal_err, 1);
    check_eq("empty_no_valid", deal_valid, 0);
    deal_req = 0;
    tick();

    // Decode deck: 0,10,11,12,13 first, rest shuffled, junk codes interleaved.
    do_reset();
    perm[0] = 0; perm[1] = 10; perm[2] = 11; perm[3] = 12; perm[4] = 13;
    idx = 5;
    for (int v = 0; v < 52; v++)
      if (!(v == 0 || v == 10 || v == 11 || v == 12 || v == 13)) begin
        perm[idx] = v;
        idx++;
      end
    shuffle_from(5);
    stream(1, 1, 0);
    for (int k = 0; k < 5; k++) begin
      deal_req = 1;
      tick();
      check_eq("decode_valid", deal_valid, 1);
      check_eq("decode_rank", rank, exp_r[k]);
      check_eq("decode_value", value, exp_v[k]);
    end
    deal_req = 0;
    tick();
    check_eq("decode_remaining", remaining, 47);
    check_eq("hold_rank", rank, 1);
    deal_until(16);
    check_eq("low_at16", deck_low, 0);
    deal_until(15);
    check_eq("low_at15", deck_low, 1);
    deal_until(0);
    check_eq("empty2_flag", deck_empty, 1);

    // Reset in the same cycle as a deal request.
    do_reset();
    for (int i = 0; i < 52; i++) perm[i] = i;
    shuffle_from(0);
    stream(1, 1, 0);
    deal_until(45);
    deal_req = 1;
    rst      = 1;
    loadFlag = 0;
    tick();
    check_eq("rstdeal_valid", deal_valid, 0);
    check_eq("rstdeal_ready", ready, 0);
    check_eq("rstdeal_remaining", remaining, 0);
    rst      = 0;
    deal_req = 0;

    // Held duplicate then out-of-range code: one capture only.
    shuffle_from(0);
    loadFlag = 1;
    card     = 6'(perm[0]);
    repeat (6) tick();
    card = 6'd60;
    repeat (2) tick();
    stream(1, 1, 1);
    check_eq("reload_ready", ready, 1);
    deal_req = 1;
    tick();
    deal_req = 0;
    check_eq("reload_first_card", card_out, perm[0]);
    check_eq("reload_remaining", remaining, 51);
    deal_until(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
